// File: rtl/mem_stage_lsu.sv
// Memory stage of the 5-stage RISC-V pipeline: latches the EX result and runs
// load/store accesses over a req/ack handshake, with misalignment and timeout detection.
module mem_stage_lsu #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        EX_valid,
   input  logic        EX_wr_en,
   input  logic [4:0]  EX_rd_sel,
   input  logic [31:0] EX_alu_val,
   input  logic [31:0] EX_store_val,
   input  logic        EX_mem_rd,
   input  logic        EX_mem_wr,
   input  logic [2:0]  EX_funct3,
   input  logic        flush,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        MEM_wr_en,
   output logic [4:0]  MEM_rd_sel,
   output logic [31:0] MEM_rd_val,
   output logic        mem_stall,
   output logic        misalign_err,
   output logic        bus_err
);
   localparam int unsigned WCNT_W = $clog2(TIMEOUT);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

   typedef enum logic { IDLE, ACCESS } state_t;

   // Access size code: 00 byte, 01 half, 10 word. Undefined funct3 falls back to word.
   function automatic logic [1:0] acc_size(input logic wr, input logic [2:0] f3);
      logic [1:0] sz;
      sz = 2'b10;
      if (wr) begin
         if (f3 == 3'b000)      sz = 2'b00;
         else if (f3 == 3'b001) sz = 2'b01;
      end else begin
         if (f3[1:0] == 2'b00)      sz = 2'b00;
         else if (f3[1:0] == 2'b01) sz = 2'b01;
      end
      return sz;
   endfunction

   function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
      return ((sz == 2'b01) && a[0]) || ((sz == 2'b10) && (a != 2'b00));
   endfunction

   logic              s_valid, s_wr_en, s_rd, s_wr;
   logic [4:0]        s_rd_sel;
   logic [31:0]       s_addr, s_wdata;
   logic [2:0]        s_funct3;
   logic [WCNT_W-1:0] wcnt, wcnt_n;
   state_t            state, state_n;
   logic              bus_err_n;
   logic              ex_access;
   logic [31:0]       lane;
   logic [31:0]       load_val;

   assign misalign_err = s_valid & (s_rd | s_wr) &
                         misaligned(acc_size(s_wr, s_funct3), s_addr[1:0]);
   // bus_err marks the cycle after an abandoned access; the stage is empty then anyway.
   assign dmem_req  = s_valid & (s_rd | s_wr) & ~misalign_err & ~bus_err;
   assign mem_stall = dmem_req & ~dmem_ack;
   assign ex_access = EX_valid & ~flush & (EX_mem_rd | EX_mem_wr) &
                      ~misaligned(acc_size(EX_mem_wr, EX_funct3), EX_alu_val[1:0]);

   always_comb begin
      state_n   = state;
      wcnt_n    = wcnt;
      bus_err_n = 1'b0;
      if (!mem_stall) begin
         wcnt_n  = '0;
         state_n = ex_access ? ACCESS : IDLE;
      end else if (flush) begin
         wcnt_n  = '0;
         state_n = IDLE;
      end else if (wcnt == WCNT_LAST) begin
         wcnt_n    = '0;
         state_n   = IDLE;
         bus_err_n = 1'b1;
      end else begin
         wcnt_n = wcnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         wcnt     <= '0;
         bus_err  <= 1'b0;
         s_valid  <= 1'b0;
         s_wr_en  <= 1'b0;
         s_rd_sel <= '0;
         s_addr   <= '0;
         s_wdata  <= '0;
         s_rd     <= 1'b0;
         s_wr     <= 1'b0;
         s_funct3 <= '0;
      end else begin
         state   <= state_n;
         wcnt    <= wcnt_n;
         bus_err <= bus_err_n;
         if (!mem_stall) begin
            s_valid  <= EX_valid & ~flush;
            s_wr_en  <= EX_wr_en;
            s_rd_sel <= EX_rd_sel;
            s_addr   <= EX_alu_val;
            s_wdata  <= EX_store_val;
            s_rd     <= EX_mem_rd;
            s_wr     <= EX_mem_wr;
            s_funct3 <= EX_funct3;
         end else if (flush || wcnt == WCNT_LAST) begin
            s_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_be    = '0;
      dmem_wdata = '0;
      if (dmem_req) begin
         dmem_we   = s_wr;
         dmem_addr = {s_addr[31:2], 2'b00};
         dmem_be   = 4'b1111;
         if (s_wr) begin
            dmem_wdata = s_wdata;
            if (s_funct3 == 3'b000) begin
               dmem_be    = 4'b0001 << s_addr[1:0];
               dmem_wdata = {4{s_wdata[7:0]}};
            end else if (s_funct3 == 3'b001) begin
               dmem_be    = 4'b0011 << s_addr[1:0];
               dmem_wdata = {2{s_wdata[15:0]}};
            end
         end
      end
   end

   always_comb begin
      lane = dmem_rdata >> {s_addr[1:0], 3'b000};
      case (s_funct3)
         3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
         3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
         3'b100:  load_val = {24'd0, lane[7:0]};
         3'b101:  load_val = {16'd0, lane[15:0]};
         default: load_val = dmem_rdata;
      endcase
   end

   assign MEM_wr_en  = s_valid & s_wr_en & ~mem_stall & ~misalign_err & ~s_wr;
   assign MEM_rd_sel = s_valid ? s_rd_sel : '0;
   assign MEM_rd_val = !s_valid ? '0 : (s_rd ? load_val : s_addr);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed instructions, a programmable-latency
// data memory responder, and monitors that pop expected writebacks and requests.
module tb_mem_stage_lsu;
   logic        clk = 1'b0;
   logic        rst;
   logic        EX_valid, EX_wr_en, EX_mem_rd, EX_mem_wr, flush;
   logic [4:0]  EX_rd_sel;
   logic [31:0] EX_alu_val, EX_store_val;
   logic [2:0]  EX_funct3;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        MEM_wr_en, mem_stall, misalign_err, bus_err;
   logic [4:0]  MEM_rd_sel;
   logic [31:0] MEM_rd_val;

   mem_stage_lsu #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .EX_valid(EX_valid), .EX_wr_en(EX_wr_en),
      .EX_rd_sel(EX_rd_sel), .EX_alu_val(EX_alu_val), .EX_store_val(EX_store_val),
      .EX_mem_rd(EX_mem_rd), .EX_mem_wr(EX_mem_wr), .EX_funct3(EX_funct3),
      .flush(flush), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata), .MEM_wr_en(MEM_wr_en), .MEM_rd_sel(MEM_rd_sel),
      .MEM_rd_val(MEM_rd_val), .mem_stall(mem_stall), .misalign_err(misalign_err),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct { logic [4:0] rd; logic [31:0] val; } wb_t;
   typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic chk_wd; } rq_t;

   wb_t wb_q[$];
   rq_t rq_q[$];
   int  errors = 0;
   int  checks = 0;
   int  ack_after = -1;
   int  ack_cnt = 0;
   logic [31:0] rd_word = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Data memory: acks after ack_after stalled cycles (negative = never).
   always @(posedge clk) begin
      #1;
      if (dmem_ack) begin
         dmem_ack = 1'b0;
         ack_cnt  = 0;
      end
      if (dmem_req && ack_after >= 0) begin
         if (ack_cnt == ack_after) begin
            dmem_ack   = 1'b1;
            dmem_rdata = rd_word;
         end else begin
            ack_cnt++;
         end
      end else if (!dmem_req) begin
         ack_cnt = 0;
      end
   end

   always @(negedge clk) begin
      wb_t e;
      rq_t r;
      if (!rst) begin
         if (MEM_wr_en) begin
            if (wb_q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
            else begin
               e = wb_q.pop_front();
               chk("wb_rd_sel", {27'd0, MEM_rd_sel}, {27'd0, e.rd});
               chk("wb_rd_val", MEM_rd_val, e.val);
            end
         end
         if (dmem_req && dmem_ack) begin
            if (rq_q.size() == 0) chk("req_unexpected", 32'd1, 32'd0);
            else begin
               r = rq_q.pop_front();
               chk("req_we", {31'd0, dmem_we}, {31'd0, r.we});
               chk("req_addr", dmem_addr, r.addr);
               chk("req_be", {28'd0, dmem_be}, {28'd0, r.be});
               if (r.chk_wd) chk("req_wdata", dmem_wdata, r.wdata);
            end
         end
      end
   end

   task automatic set_ex(input logic v, input logic we, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] sv, input logic mrd, input logic mwr, input logic [2:0] f3);
      EX_valid = v; EX_wr_en = we; EX_rd_sel = rd; EX_alu_val = alu;
      EX_store_val = sv; EX_mem_rd = mrd; EX_mem_wr = mwr; EX_funct3 = f3;
   endtask

   task automatic bubble();
      set_ex(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0);
   endtask

   // Called just after an edge; instruction is captured at the next edge.
   task automatic issue(input logic we, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] sv, input logic mrd, input logic mwr, input logic [2:0] f3);
      set_ex(1'b1, we, rd, alu, sv, mrd, mwr, f3);
      @(posedge clk); #1;
      bubble();
   endtask

   // Counts stalled cycles; returns at the negedge of the first non-stalled cycle.
   task automatic wait_stall(output int n);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!mem_stall) break;
         n++;
      end
   endtask

   task automatic mem_op(input string name, input int lat, input logic [31:0] word,
                         input logic we, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] sv, input logic mrd, input logic mwr, input logic [2:0] f3);
      int n;
      ack_after = lat;
      rd_word   = word;
      issue(we, rd, alu, sv, mrd, mwr, f3);
      wait_stall(n);
      chk({name, "_stall_cycles"}, n, lat);
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      rst = 1'b1; flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
      bubble();
      @(negedge clk); @(negedge clk);
      chk("rst_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_wr_en", {31'd0, MEM_wr_en}, 32'd0);
      chk("rst_rd_val", MEM_rd_val, 32'd0);
      chk("rst_stall", {31'd0, mem_stall}, 32'd0);
      chk("rst_wcnt", 32'(dut.wcnt), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // ALU result passes through one cycle after capture
      wb_q.push_back('{5'd5, 32'h0000_1234});
      issue(1'b1, 5'd5, 32'h0000_1234, 32'd0, 1'b0, 1'b0, 3'b000);
      @(negedge clk);
      chk("alu_req", {31'd0, dmem_req}, 32'd0);
      @(posedge clk); #1;

      // Loads with lane select and extension
      rq_q.push_back('{1'b0, 32'h100, 4'hF, 32'd0, 1'b0});
      wb_q.push_back('{5'd7, 32'hFFFF_FF80});
      mem_op("lb", 3, 32'h80FF_FFFF, 1'b1, 5'd7, 32'h103, 32'd0, 1'b1, 1'b0, 3'b000);
      rq_q.push_back('{1'b0, 32'h100, 4'hF, 32'd0, 1'b0});
      wb_q.push_back('{5'd8, 32'h0000_0080});
      mem_op("lbu", 0, 32'h80FF_FFFF, 1'b1, 5'd8, 32'h103, 32'd0, 1'b1, 1'b0, 3'b100);
      rq_q.push_back('{1'b0, 32'h100, 4'hF, 32'd0, 1'b0});
      wb_q.push_back('{5'd9, 32'hFFFF_80FF});
      mem_op("lh", 1, 32'h80FF_FFFF, 1'b1, 5'd9, 32'h102, 32'd0, 1'b1, 1'b0, 3'b001);
      rq_q.push_back('{1'b0, 32'h100, 4'hF, 32'd0, 1'b0});
      wb_q.push_back('{5'd10, 32'h0000_80FF});
      mem_op("lhu", 1, 32'h80FF_FFFF, 1'b1, 5'd10, 32'h102, 32'd0, 1'b1, 1'b0, 3'b101);
      rq_q.push_back('{1'b0, 32'h100, 4'hF, 32'd0, 1'b0});
      wb_q.push_back('{5'd11, 32'h0000_0056});
      mem_op("lbu1", 1, 32'h1234_5678, 1'b1, 5'd11, 32'h101, 32'd0, 1'b1, 1'b0, 3'b100);
      rq_q.push_back('{1'b0, 32'h100, 4'hF, 32'd0, 1'b0});
      wb_q.push_back('{5'd12, 32'h1234_5678});
      mem_op("lw", 0, 32'h1234_5678, 1'b1, 5'd12, 32'h100, 32'd0, 1'b1, 1'b0, 3'b010);

      // Stores: wr_en set on purpose; stores must never write back
      rq_q.push_back('{1'b1, 32'h200, 4'b1100, 32'h1234_1234, 1'b1});
      mem_op("sh", 2, 32'd0, 1'b1, 5'd3, 32'h202, 32'hABCD_1234, 1'b0, 1'b1, 3'b001);
      rq_q.push_back('{1'b1, 32'h200, 4'b0010, 32'h5656_5656, 1'b1});
      mem_op("sb", 1, 32'd0, 1'b1, 5'd3, 32'h201, 32'h0000_0056, 1'b0, 1'b1, 3'b000);
      rq_q.push_back('{1'b1, 32'h204, 4'b1111, 32'hDEAD_BEEF, 1'b1});
      mem_op("sw", 0, 32'd0, 1'b0, 5'd0, 32'h204, 32'hDEAD_BEEF, 1'b0, 1'b1, 3'b010);

      // Misaligned LW and LH
      issue(1'b1, 5'd13, 32'h301, 32'd0, 1'b1, 1'b0, 3'b010);
      @(negedge clk);
      chk("mis_lw_err", {31'd0, misalign_err}, 32'd1);
      chk("mis_lw_req", {31'd0, dmem_req}, 32'd0);
      chk("mis_lw_stall", {31'd0, mem_stall}, 32'd0);
      chk("mis_lw_wr_en", {31'd0, MEM_wr_en}, 32'd0);
      @(posedge clk); #1;
      issue(1'b1, 5'd13, 32'h101, 32'd0, 1'b1, 1'b0, 3'b001);
      @(negedge clk);
      chk("mis_lh_err", {31'd0, misalign_err}, 32'd1);
      @(posedge clk); #1;

      // Timeout: held ALU op is captured right after the abandoned load
      ack_after = -1;
      set_ex(1'b1, 1'b1, 5'd14, 32'h400, 32'd0, 1'b1, 1'b0, 3'b010);
      @(posedge clk); #1;
      set_ex(1'b1, 1'b1, 5'd15, 32'h0000_0055, 32'd0, 1'b0, 1'b0, 3'b000);
      wb_q.push_back('{5'd15, 32'h0000_0055});
      wait_stall(n);
      chk("to_stall_cycles", n, 32'd16);
      chk("to_bus_err", {31'd0, bus_err}, 32'd1);
      chk("to_req", {31'd0, dmem_req}, 32'd0);
      @(posedge clk); #1;
      bubble();
      @(negedge clk);
      chk("to_bus_err_pulse", {31'd0, bus_err}, 32'd0);
      @(posedge clk); #1;

      // Flush during a stall
      set_ex(1'b1, 1'b1, 5'd16, 32'h500, 32'd0, 1'b1, 1'b0, 3'b010);
      @(posedge clk); #1;
      bubble();
      @(negedge clk); @(negedge clk);
      chk("fl_stall_before", {31'd0, mem_stall}, 32'd1);
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("fl_req", {31'd0, dmem_req}, 32'd0);
      chk("fl_stall", {31'd0, mem_stall}, 32'd0);
      chk("fl_wcnt", 32'(dut.wcnt), 32'd0);
      @(posedge clk); #1;

      // Asynchronous reset during an access
      set_ex(1'b1, 1'b1, 5'd17, 32'h601, 32'd0, 1'b1, 1'b0, 3'b100);
      @(posedge clk); #1;
      bubble();
      @(negedge clk); @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("ar_req", {31'd0, dmem_req}, 32'd0);
      chk("ar_stall", {31'd0, mem_stall}, 32'd0);
      chk("ar_rd_sel", {27'd0, MEM_rd_sel}, 32'd0);
      chk("ar_addr", dmem_addr, 32'd0);
      chk("ar_be", {28'd0, dmem_be}, 32'd0);
      chk("ar_wcnt", 32'(dut.wcnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Normal operation after reset
      rq_q.push_back('{1'b0, 32'h600, 4'hF, 32'd0, 1'b0});
      wb_q.push_back('{5'd18, 32'hFFFF_FFBB});
      mem_op("post_lb", 2, 32'h00BB_0000, 1'b1, 5'd18, 32'h602, 32'd0, 1'b1, 1'b0, 3'b000);

      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("wb_q_drained", wb_q.size(), 32'd0);
      chk("rq_q_drained", rq_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory stage of the 5-stage RISC-V pipeline. Sits between execute and pipeline_reg_writeback and drives that register's MEM_wr_en, MEM_rd_sel and MEM_rd_val inputs.
- Latches the EX result, performs load/store accesses to data memory over a req/ack handshake, and formats load data (byte lanes, sign/zero extension).
- Stalls the front of the pipeline while an access is outstanding.
- Flags misaligned accesses, and flags accesses that time out with no ack.

Parameters:
- TIMEOUT, 16, maximum cycles dmem_req is held without dmem_ack before the access is abandoned; must be at least 2.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-high.
- EX_valid  in  1  EX stage holds a real instruction.
- EX_wr_en  in  1  instruction writes rd.
- EX_rd_sel  in  5  destination register.
- EX_alu_val  in  32  ALU result; this is the effective address for loads/stores.
- EX_store_val  in  32  rs2 value for stores.
- EX_mem_rd  in  1  load instruction.
- EX_mem_wr  in  1  store instruction.
- EX_funct3  in  3  RISC-V funct3 (access size and sign).
- flush  in  1  kill the instruction held in the stage.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-aligned store data.
- dmem_ack  in  1  access complete; dmem_rdata is valid in this cycle only.
- dmem_rdata  in  32  read word.
- MEM_wr_en  out  1  to pipeline_reg_writeback.
- MEM_rd_sel  out  5  to pipeline_reg_writeback.
- MEM_rd_val  out  32  to pipeline_reg_writeback.
- mem_stall  out  1  hold PC, IF/ID and EX; do not advance.
- misalign_err  out  1  held access is misaligned.
- bus_err  out  1  one-cycle pulse when an access times out.

Behaviour:
- Stage registers: s_valid, s_wr_en, s_rd_sel, s_addr, s_wdata, s_rd, s_wr, s_funct3, wait counter wcnt, state {IDLE, ACCESS}.
- Reset clears every stage register, sets state to IDLE and wcnt to 0. With no stage contents, every output is 0.
- Capture: at posedge, if mem_stall=0, the stage loads all EX_* inputs.
  - If flush=1 at that edge, s_valid is loaded as 0 instead.
  - If mem_stall=1, the stage holds its contents.
- Flush priority: flush=1 during ACCESS clears s_valid, returns to IDLE and zeroes wcnt. The request drops the next cycle. Data memory tolerates req withdrawal; an abandoned store may or may not have completed.
- Misalignment is combinational:
  - misalign_err = s_valid & (s_rd|s_wr) & ((size==half & s_addr[0]) | (size==word & s_addr[1:0]!=0)).
  - A misaligned access issues no request, never stalls, and forces MEM_wr_en=0.
- dmem_req = s_valid & (s_rd|s_wr) & ~misalign_err & ~timed_out.
  - State is ACCESS while dmem_req=1.
  - dmem_we = s_wr.
- mem_stall = dmem_req & ~dmem_ack. If dmem_ack arrives in the first request cycle, the access costs zero stall cycles.
- Timeout:
  - wcnt increments on each stalled cycle.
  - When wcnt reaches TIMEOUT-1 and there is still no ack, at that edge bus_err pulses high for the next cycle, s_valid clears, wcnt resets, and the state returns to IDLE.
  - The instruction is discarded with MEM_wr_en=0. The stage captures EX on the following edge.
- Stores (funct3 000/001/010):
  - SB: be = 0001<<addr[1:0], wdata = {4{byte}}.
  - SH: be = 0011<<addr[1:0], wdata = {2{half}}.
  - SW: be = 1111, wdata = word.
- Loads: loads assert be=1111. The lane is selected by s_addr[1:0].
  - LB 000 sign-extends the byte.
  - LH 001 sign-extends the half.
  - LW 010 passes the word.
  - LBU 100 zero-extends the byte.
  - LHU 101 zero-extends the half.
  - Other funct3 values are treated as LW/SW.
- Outputs, all combinational from stage state:
  - MEM_rd_sel = s_rd_sel.
  - MEM_rd_val = formatted dmem_rdata for a load, else s_addr (the ALU result).
  - MEM_wr_en = s_valid & s_wr_en & ~mem_stall & ~misalign_err & ~s_wr.
- Load result timing: the result is valid only in the ack cycle. The writeback register latches it at that edge, and the stage captures the next EX instruction at the same edge.
- Latency: a non-memory instruction is at the outputs in the cycle after capture. A load is at the outputs in its ack cycle.
- Simultaneous dmem_ack and timeout edge: the ack wins and the access completes normally.

Test Plan:
- ALU op: EX_alu_val=0x1234, rd=5, wr_en=1 -> next cycle MEM_wr_en=1, rd_sel=5, rd_val=0x1234, dmem_req=0.
- LB from addr 0x103, rdata=0x80FFFFFF, ack after 3 cycles -> mem_stall=1 for 3 cycles, dmem_addr=0x100, rd_val=0xFFFFFF80 in the ack cycle. LBU of the same access -> 0x00000080.
- SH addr 0x202, rs2=0xABCD1234 -> be=1100, wdata=0x12341234, MEM_wr_en=0, stall ends on ack.
- LW addr 0x301 -> misalign_err=1, dmem_req=0, mem_stall=0, MEM_wr_en=0.
- Load with no ack, TIMEOUT=16 -> stall for exactly 16 cycles, bus_err one-cycle pulse, MEM_wr_en never 1, the next instruction captured afterwards.
- Flush asserted mid-stall, and rst asserted mid-ACCESS -> dmem_req low next cycle. Under rst, all outputs are 0 immediately (asynchronous) and wcnt=0.
